// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the five-stage core's pipeline control:
//   - address bus width and address type
//   - stage index constants (PC, IF, ID, EX, MEM) and stage count
//   - helper that locates the deepest stage currently requesting a stall
// No ports; imported by pipeline_ctrl and redirect_buffer.
package pipeline_ctrl_pkg;

  localparam int ADDR_BUS_WIDTH = 32;
  typedef logic [ADDR_BUS_WIDTH-1:0] addr_t;

  localparam int STAGE_PC    = 0;
  localparam int STAGE_IF    = 1;
  localparam int STAGE_ID    = 2;
  localparam int STAGE_EX    = 3;
  localparam int STAGE_MEM   = 4;
  localparam int STAGE_COUNT = 5;

  // Index of the deepest stage with an active stall request.
  // Returns 0 when nothing is requesting; callers must qualify with
  // the "any request" flag because index 0 is also the PC stage.
  function automatic logic [2:0] deepest_req(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [2:0] idx;
    idx = 3'd0;
    if (req_if)  idx = 3'(STAGE_IF);
    if (req_id)  idx = 3'(STAGE_ID);
    if (req_ex)  idx = 3'(STAGE_EX);
    if (req_mem) idx = 3'(STAGE_MEM);
    return idx;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_redirect_buffer.sv
// redirect_buffer
// Holds a fetch redirect (target PC plus valid flag) until the PC unit
// accepts it, and tracks the RUN/HOLD control state.
// Ports:
//   clk            in   core clock, rising edge
//   rst            in   synchronous active-low reset
//   exception      in   MEM exception / ERET commit (accepted in any state)
//   exception_pc   in   handler / EPC target
//   mp_accept      in   mispredict already qualified by the controller
//   mispredict_pc  in   corrected branch target
//   redirect_ready in   PC unit accepts the redirect this cycle
//   redirect_valid out  registered redirect valid
//   redirect_pc    out  registered redirect target
//   hold           out  1 while a redirect is outstanding (HOLD state)
module redirect_buffer
  import pipeline_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  exception,
  input  addr_t exception_pc,
  input  logic  mp_accept,
  input  addr_t mispredict_pc,
  input  logic  redirect_ready,
  output logic  redirect_valid,
  output addr_t redirect_pc,
  output logic  hold
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic       valid_reg;
  logic       valid_next;
  addr_t      pc_reg;
  addr_t      pc_next;

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    pc_next    = pc_reg;
    case (state_reg)
      ST_RUN: begin
        // Exception wins over a simultaneous mispredict.
        if (exception) begin
          state_next = ST_HOLD;
          valid_next = 1'b1;
          pc_next    = exception_pc;
        end else if (mp_accept) begin
          state_next = ST_HOLD;
          valid_next = 1'b1;
          pc_next    = mispredict_pc;
        end
      end
      ST_HOLD: begin
        // A new exception replaces the pending target even in the
        // handshake cycle; the old target is then simply dropped.
        if (exception) begin
          valid_next = 1'b1;
          pc_next    = exception_pc;
        end else if (valid_reg && redirect_ready) begin
          state_next = ST_RUN;
          valid_next = 1'b0;
        end
        // Mispredicts in HOLD are wrong-path and ignored.
      end
      default: begin
        state_next = ST_RUN;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      valid_reg <= 1'b0;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      pc_reg    <= pc_next;
    end
  end

  assign redirect_valid = valid_reg;
  assign redirect_pc    = pc_reg;
  assign hold           = (state_reg == ST_HOLD);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush/redirect controller for the five-stage in-order
// core. Merges per-stage stall requests, EX mispredicts and MEM
// exception/ERET redirects into one stall vector and one flush vector
// (bit k acts on the register at the output of stage k: PC, IF, ID, EX,
// MEM) and buffers the fetch redirect until the PC unit accepts it.
// Optional feature macro: STALL_PERF_EN (front-end stall cycle counter;
// when undefined stall_cycles is tied to zero and no counter is built).
// Ports:
//   clk            in   core clock
//   rst            in   synchronous active-low reset
//   stall_req_if   in   I-cache miss
//   stall_req_id   in   load-use hazard
//   stall_req_ex   in   multi-cycle mul/div busy
//   stall_req_mem  in   D-cache miss
//   mispredict     in   EX branch mispredict (held by EX while stalled)
//   mispredict_pc  in   corrected branch target
//   exception      in   MEM commits exception or ERET
//   exception_pc   in   handler / EPC target
//   redirect_ready in   PC unit accepts the redirect
//   stall          out  [4:0] hold register at output of stage k
//   flush          out  [4:0] bubble register at output of stage k
//   redirect_valid out  registered redirect valid
//   redirect_pc    out  registered redirect target
//   stall_cycles   out  [31:0] saturating count of cycles with stall[0]
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        mispredict,
  input  logic [ADDR_BUS_WIDTH-1:0] mispredict_pc,
  input  logic        exception,
  input  logic [ADDR_BUS_WIDTH-1:0] exception_pc,
  input  logic        redirect_ready,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        redirect_valid,
  output logic [ADDR_BUS_WIDTH-1:0] redirect_pc,
  output logic [31:0] stall_cycles
);

  logic       any_req;
  logic [2:0] deepest;
  logic [STAGE_COUNT-1:0] req_mask;
  logic       hold;
  logic       mp_accept;

  assign any_req = stall_req_if | stall_req_id | stall_req_ex | stall_req_mem;
  assign deepest = deepest_req(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);

  // Everything at or upstream of the deepest requesting stage holds.
  // The bubble into the first non-stalled stage falls out of the
  // stall/next-stall pairing in the pipeline registers themselves.
  generate
    for (genvar gi = 0; gi < STAGE_COUNT; gi++) begin : g_mask
      localparam logic [2:0] STAGE_IDX = 3'(gi);
      assign req_mask[gi] = any_req && (STAGE_IDX <= deepest);
    end
  endgenerate

  always_comb begin
    stall     = '0;
    flush     = '0;
    mp_accept = 1'b0;
    if (!rst) begin
      flush = 5'b11111;
    end else if (exception) begin
      // Exception overrides every stall and mispredict.
      flush = 5'b11111;
    end else begin
      stall = req_mask;
      if (hold) begin
        // PC must not self-increment and anything fetched meanwhile is
        // wrong-path until the redirect is taken.
        stall[STAGE_PC] = 1'b1;
        flush[STAGE_IF] = 1'b1;
      end else if (mispredict && !req_mask[STAGE_EX]) begin
        // While EX is stalled the branch is re-presented later.
        mp_accept       = 1'b1;
        flush[STAGE_IF] = 1'b1;
        flush[STAGE_ID] = 1'b1;
      end
    end
  end

  redirect_buffer u_redirect_buffer (
    .clk            (clk),
    .rst            (rst),
    .exception      (exception),
    .exception_pc   (exception_pc),
    .mp_accept      (mp_accept),
    .mispredict_pc  (mispredict_pc),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hold           (hold)
  );

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_reg <= '0;
    end else if (stall[STAGE_PC] && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed-vector bench for pipeline_ctrl with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; combinational outputs
// are checked 1 unit later, registered outputs 1 unit after the edge.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        mispredict;
  logic [31:0] mispredict_pc;
  logic        exception;
  logic [31:0] exception_pc;
  logic        redirect_ready;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req_if   (stall_req_if),
    .stall_req_id   (stall_req_id),
    .stall_req_ex   (stall_req_ex),
    .stall_req_mem  (stall_req_mem),
    .mispredict     (mispredict),
    .mispredict_pc  (mispredict_pc),
    .exception      (exception),
    .exception_pc   (exception_pc),
    .redirect_ready (redirect_ready),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
    mispredict = 0; exception = 0; redirect_ready = 0;
  endtask

  // Check combinational outputs for the currently applied inputs.
  task automatic comb(input string tag, input logic [4:0] exp_stall, input logic [4:0] exp_flush);
    #1;
    chk({tag, ".stall"}, {27'd0, stall}, {27'd0, exp_stall});
    chk({tag, ".flush"}, {27'd0, flush}, {27'd0, exp_flush});
  endtask

  task automatic regs(input string tag, input logic exp_valid, input logic [31:0] exp_pc);
    chk({tag, ".valid"}, {31'd0, redirect_valid}, {31'd0, exp_valid});
    chk({tag, ".pc"}, redirect_pc, exp_pc);
  endtask

  initial begin
    idle();
    mispredict_pc = 32'h0; exception_pc = 32'h0;
    rst = 0;
    #1;
    tick(); tick();
    comb("reset", 5'b00000, 5'b11111);
    regs("reset", 1'b0, 32'h0);
    chk("reset.cycles", stall_cycles, 32'd0);

    // Stall vector
    rst = 1;
    comb("idle", 5'b00000, 5'b00000);
    stall_req_id = 1;
    comb("req_id", 5'b00111, 5'b00000);
    stall_req_mem = 1;
    comb("req_id_mem", 5'b11111, 5'b00000);
    idle(); stall_req_if = 1;
    comb("req_if", 5'b00011, 5'b00000);
    idle(); stall_req_ex = 1;
    comb("req_ex", 5'b01111, 5'b00000);

    // Mispredict, immediate handshake
    tick(); idle();
    mispredict = 1; mispredict_pc = 32'h8000_0100;
    comb("mp", 5'b00000, 5'b00110);
    tick(); mispredict = 0;
    regs("mp+1", 1'b1, 32'h8000_0100);
    redirect_ready = 1;
    comb("mp_hold", 5'b00001, 5'b00010);
    tick(); redirect_ready = 0;
    regs("mp_done", 1'b0, 32'h8000_0100);
    comb("mp_run", 5'b00000, 5'b00000);

    // Mispredict blocked by D-cache miss for 3 cycles
    mispredict = 1; mispredict_pc = 32'h8000_0200; stall_req_mem = 1;
    for (int i = 0; i < 3; i++) begin
      comb($sformatf("mp_blk%0d", i), 5'b11111, 5'b00000);
      tick();
      chk($sformatf("mp_blk%0d.valid", i), {31'd0, redirect_valid}, 32'd0);
    end
    stall_req_mem = 0;
    comb("mp_unblk", 5'b00000, 5'b00110);
    tick(); mispredict = 0;
    regs("mp_unblk+1", 1'b1, 32'h8000_0200);
    // Mispredict while in HOLD is ignored
    mispredict = 1; mispredict_pc = 32'h8000_0300;
    comb("mp_in_hold", 5'b00001, 5'b00010);
    tick(); mispredict = 0;
    regs("mp_in_hold+1", 1'b1, 32'h8000_0200);
    // Exception in the handshake cycle keeps HOLD
    redirect_ready = 1; exception = 1; exception_pc = 32'h8000_0400;
    comb("exc_hs", 5'b00000, 5'b11111);
    tick(); exception = 0;
    regs("exc_hs+1", 1'b1, 32'h8000_0400);
    tick(); redirect_ready = 0;
    regs("exc_hs_done", 1'b0, 32'h8000_0400);

    // Exception together with mispredict
    exception = 1; exception_pc = 32'hBFC0_0380;
    mispredict = 1; mispredict_pc = 32'h8000_0500;
    comb("exc_mp", 5'b00000, 5'b11111);
    tick(); exception = 0; mispredict = 0;
    regs("exc_mp+1", 1'b1, 32'hBFC0_0380);

    // HOLD with ready=0 for 4 cycles, exception in cycle 3
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin
        exception = 1; exception_pc = 32'h8000_0180;
        comb("hold_c3", 5'b00000, 5'b11111);
      end else begin
        comb($sformatf("hold_c%0d", c), 5'b00001, 5'b00010);
      end
      tick(); exception = 0;
      regs($sformatf("hold_c%0d+1", c), 1'b1, (c >= 3) ? 32'h8000_0180 : 32'hBFC0_0380);
    end

    // Reset during HOLD
    rst = 0;
    comb("rst_hold", 5'b00000, 5'b11111);
    tick(); rst = 1;
    regs("rst_hold+1", 1'b0, 32'h0);
    comb("rst_run", 5'b00000, 5'b00000);

    // Front-end stall counter: 10 cycles of I-cache miss from a clean reset
    rst = 0;
    tick(); rst = 1; stall_req_if = 1;
    for (int i = 0; i < 10; i++) tick();
    stall_req_if = 0;
`ifdef STALL_PERF_EN
    chk("cycles10", stall_cycles, 32'd10);
`else
    chk("cycles10", stall_cycles, 32'd0);
`endif
    rst = 0;
    tick(); rst = 1;
    chk("cycles_rst", stall_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/redirect controller for the five-stage in-order core. It merges per-stage stall requests, branch-mispredict reports from EX and exception/ERET redirects from MEM into one stall vector and one flush vector. These drive every inter-stage pipeline register (IFID, IDEX, EXMEM, MEMWB) and the PC register. It also holds the fetch redirect with a valid/ready handshake until the PC unit accepts it.

## Interface
- No parameters. Widths come from shared `ADDR_BUS` / `ADDR_BUS_WIDTH`.
- Stage index k: PC=0, IF=1, ID=2, EX=3, MEM=4.
- Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- stall_req_if  in  1  I-cache miss
- stall_req_id  in  1  load-use hazard
- stall_req_ex  in  1  multi-cycle mul/div busy
- stall_req_mem  in  1  D-cache miss
- mispredict  in  1  EX branch resolved opposite to prediction; held by EX while EX is stalled
- mispredict_pc  in  `ADDR_BUS`  correct target
- exception  in  1  MEM commits exception or ERET
- exception_pc  in  `ADDR_BUS`  handler / EPC target
- redirect_ready  in  1  PC unit accepts redirect this cycle
- stall  out  5  bit k holds the register at the output of stage k
- flush  out  5  bit k clears the register at the output of stage k to a bubble
- redirect_valid  out  1  registered
- redirect_pc  out  `ADDR_BUS`  registered
- stall_cycles  out  32  front-end stall counter; see Configuration

## Operation
- **Stall vector:** h = highest k with an active request (if→1, id→2, ex→3, mem→4). stall[k]=1 for all k≤h; other bits are 0. No request gives stall=0.
- **Bubble rule:** a register whose source stage is stalled but whose destination is not inserts a bubble. This behaviour is inherent in the stall/next-stall pairing; the controller drives no extra flush for it.
- **Exception:** accepted in any state. Highest priority; overrides all stall requests and any mispredict.
  - Same cycle: flush=5'b11111, stall=0.
  - Next cycle: redirect_pc ← exception_pc.
- **Mispredict:** accepted only in RUN, with exception=0 and stall[3]=0.
  - Same cycle: flush[1]=flush[2]=1 (IFID, IDEX); other flush bits 0; stall unchanged.
  - Next cycle: redirect_pc ← mispredict_pc.
  - While stall[3]=1 it is ignored; EX re-presents it.
- **FSM states:** RUN, HOLD.
  - RUN → HOLD on an accepted event; redirect_valid=1 from the next cycle.
  - HOLD → RUN at the edge where redirect_valid & redirect_ready & !exception.
  - HOLD with exception: redirect_pc overwritten with exception_pc; stays HOLD, including in the handshake cycle.
  - HOLD with mispredict: ignored.
- **In HOLD:** flush[1]=1 every cycle to discard wrong-path fetch; stall[0]=1 (PC not self-incremented). Other bits follow the normal rules.
- **Reset (rst=0):** state=RUN, redirect_valid=0, redirect_pc=0, stall_cycles=0. Combinational outputs during reset: flush=5'b11111, stall=0.

## Timing
- stall and flush are combinational from the current inputs and state, with zero latency.
- redirect_valid and redirect_pc are registered: they appear 1 cycle after the triggering event.
- A handshake completes on the edge where valid=ready=1. redirect_valid is 0 in the following cycle unless a new exception arrived in the handshake cycle.
- Minimum event-to-RUN time is 2 cycles: event cycle, then handshake cycle with ready=1.
- redirect_pc is stable while in HOLD except on an exception overwrite.

## Configuration
- `STALL_PERF_EN` defined: stall_cycles counts each non-reset cycle with stall[0]=1 and saturates at 32'hFFFFFFFF.
- `STALL_PERF_EN` undefined: stall_cycles is tied to 0 and no counter flops are built. The port is kept in both builds.

## Structure
- Stage index constants (`STAGE_PC`…`STAGE_MEM`, `STAGE_COUNT`=5) go in a shared pipeline header alongside `bus.v`. FSM state encodings stay local.
- One sub-module, redirect_buffer: holds the FSM, redirect_pc and redirect_valid, and the handshake logic. The stall/flush combinational logic and the counter stay in pipeline_ctrl.

## Test plan
- stall_req_id=1 alone → stall=5'b00111, flush=0. Add stall_req_mem=1 → stall=5'b11111.
- mispredict=1, mispredict_pc=0x8000_0100, no stalls → flush=5'b00110 that cycle. Next cycle: redirect_valid=1, pc=0x8000_0100. ready=1 → RUN, valid=0 on the following cycle.
- mispredict with stall_req_mem=1 for 3 cycles → no flush and no redirect for those cycles; accepted in the first cycle after stall_req_mem drops.
- exception (pc=0xBFC0_0380) in the same cycle as a mispredict → flush=5'b11111, redirect_pc=0xBFC0_0380.
- In HOLD with ready=0 for 4 cycles → flush[1]=1 and stall[0]=1 each cycle. Exception in cycle 3 with pc=0x8000_0180 → redirect_pc updates to 0x8000_0180 and valid stays 1.
- rst=0 during HOLD → next cycle valid=0, state RUN. With `STALL_PERF_EN`: 10 cycles of stall_req_if → stall_cycles=10; after reset → 0.
